// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage.
//   - ALU opcode constants (AND, OR, ADD, SUB)
//   - alu_op_legal(): returns 1 for an opcode the ALU implements
//   - alu_req_t: request record {a, b, op, tag} at the default widths.
//     It is also the default payload type of alu_skid_buf.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   localparam int ALU_WIDTH_DEF = 32;
   localparam int ALU_TAG_W_DEF = 4;

   typedef struct packed {
      logic [ALU_WIDTH_DEF-1:0] a;
      logic [ALU_WIDTH_DEF-1:0] b;
      logic [2:0]               op;
      logic [ALU_TAG_W_DEF-1:0] tag;
   } alu_req_t;

   function automatic logic alu_op_legal(input logic [2:0] op);
      logic legal;
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB: legal = 1'b1;
         default:                           legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// ---------------------------------------------------------------------------
// alu_skid_buf
// One-entry skid register sitting in front of the S1 operand register.
// It generates the registered upstream ready.
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_valid, i_data : upstream request and its payload
//   i_s1_take       : S1 can accept an entry this cycle (empty or advancing)
//   o_ready         : registered, high while the skid register is empty
//   o_s1_load       : S1 should load o_s1_data at the next edge
//   o_s1_data       : skid entry if one is held, otherwise the live input
// A held skid entry always refills S1 before a new input, which keeps the
// stream in FIFO order. No input is accepted while the skid is full,
// so the skid can never be draining and filling in the same cycle.
// ---------------------------------------------------------------------------
module alu_skid_buf
   import alu_pkg::*;
#(
   parameter type T = alu_req_t
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_valid,
   input  T     i_data,
   input  logic i_s1_take,
   output logic o_ready,
   output logic o_s1_load,
   output T     o_s1_data
);

   logic r_skid_valid;
   logic r_ready;
   T     r_skid_data;
   logic w_hs;

   assign w_hs      = i_valid && r_ready;
   assign o_ready   = r_ready;
   assign o_s1_load = i_s1_take && (r_skid_valid || w_hs);
   assign o_s1_data = r_skid_valid ? r_skid_data : i_data;

   // Skid occupancy and payload; ready follows the next occupancy state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_skid_valid <= 1'b0;
         r_ready      <= 1'b1;
         r_skid_data  <= '0;
      end else if (r_skid_valid && i_s1_take) begin
         r_skid_valid <= 1'b0;
         r_ready      <= 1'b1;
      end else if (w_hs && !i_s1_take) begin
         r_skid_valid <= 1'b1;
         r_ready      <= 1'b0;
         r_skid_data  <= i_data;
      end else begin
         r_skid_valid <= r_skid_valid;
         r_ready      <= r_ready;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Two-stage pipeline around an external combinational ALU (yAlu).
//   skid (1 entry) -> S1 operand register (drives alu_*) -> S2 output register
// Up to three operations can be in flight.
//   clk, reset              : clock, synchronous active-high reset
//   in_valid/in_ready       : request handshake (in_ready registered)
//   in_a, in_b, in_op, in_tag : request payload
//   alu_a, alu_b, alu_op    : registered ALU inputs (0 after reset)
//   alu_z, alu_ex           : ALU result and zero flag
//   out_valid/out_ready     : result handshake
//   out_z, out_zero, out_err, out_tag, out_ovf : registered result
// Illegal opcodes are still accepted. The ALU is driven with AND for that
// slot, and the result is forced to z=0, zero=1, err=1.
// Optional macro ALU_ISSUE_OVF_EN: S2 captures signed overflow for ADD/SUB.
// Without it, out_ovf is tied to 0.
// ---------------------------------------------------------------------------
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_z,
   input  logic             alu_ex,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_z,
   output logic             out_zero,
   output logic             out_err,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_ovf
);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
   } req_t;

   req_t             w_in_req;
   req_t             w_s1_req;
   logic             w_s1_load;
   logic             w_s1_take;
   logic             w_s1_adv;
   logic             w_s2_free;
   logic             w_req_legal;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [2:0]       r_s1_op;
   logic             r_s1_err;
   logic [TAG_W-1:0] r_s1_tag;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_s2_z;
   logic             r_s2_zero;
   logic             r_s2_err;
   logic [TAG_W-1:0] r_s2_tag;

   // Pack the request port fields into one record for the skid path.
   always_comb begin
      w_in_req     = '0;
      w_in_req.a   = in_a;
      w_in_req.b   = in_b;
      w_in_req.op  = in_op;
      w_in_req.tag = in_tag;
   end

   // S2 frees up when it is empty or its result is consumed this cycle.
   assign w_s2_free   = !r_s2_valid || (r_s2_valid && out_ready);
   assign w_s1_adv    = r_s1_valid && w_s2_free;
   assign w_s1_take   = !r_s1_valid || w_s1_adv;
   assign w_req_legal = alu_op_legal(w_s1_req.op);

   alu_skid_buf #(
      .T (req_t)
   ) u_skid (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_valid   (in_valid),
      .i_data    (w_in_req),
      .i_s1_take (w_s1_take),
      .o_ready   (in_ready),
      .o_s1_load (w_s1_load),
      .o_s1_data (w_s1_req)
   );

   // S1 operand register; holds its contents while empty or stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= 3'b000;
         r_s1_err   <= 1'b0;
         r_s1_tag   <= '0;
      end else if (w_s1_load) begin
         r_s1_valid <= 1'b1;
         r_s1_a     <= w_s1_req.a;
         r_s1_b     <= w_s1_req.b;
         r_s1_op    <= w_req_legal ? w_s1_req.op : ALU_AND;
         r_s1_err   <= !w_req_legal;
         r_s1_tag   <= w_s1_req.tag;
      end else if (w_s1_adv) begin
         r_s1_valid <= 1'b0;
      end else begin
         r_s1_valid <= r_s1_valid;
      end
   end

   assign alu_a  = r_s1_a;
   assign alu_b  = r_s1_b;
   assign alu_op = r_s1_op;

   // S2 output register; reloads in the same cycle its result is consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s2_valid <= 1'b0;
         r_s2_z     <= '0;
         r_s2_zero  <= 1'b0;
         r_s2_err   <= 1'b0;
         r_s2_tag   <= '0;
      end else if (w_s1_adv) begin
         r_s2_valid <= 1'b1;
         r_s2_z     <= r_s1_err ? '0 : alu_z;
         r_s2_zero  <= r_s1_err ? 1'b1 : alu_ex;
         r_s2_err   <= r_s1_err;
         r_s2_tag   <= r_s1_tag;
      end else if (r_s2_valid && out_ready) begin
         r_s2_valid <= 1'b0;
      end else begin
         r_s2_valid <= r_s2_valid;
      end
   end

   assign out_valid = r_s2_valid;
   assign out_z     = r_s2_z;
   assign out_zero  = r_s2_zero;
   assign out_err   = r_s2_err;
   assign out_tag   = r_s2_tag;

`ifdef ALU_ISSUE_OVF_EN
   logic w_ovf;
   logic r_s2_ovf;

   // Signed overflow of the S1 operation. Illegal ops carry the AND
   // opcode in S1, so they fall into the default branch.
   always_comb begin
      w_ovf = 1'b0;
      case (r_s1_op)
         ALU_ADD: w_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                          (alu_z[WIDTH-1] != r_s1_a[WIDTH-1]);
         ALU_SUB: w_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                          (alu_z[WIDTH-1] != r_s1_a[WIDTH-1]);
         default: w_ovf = 1'b0;
      endcase
   end

   // Overflow flag travels with the rest of the S2 result.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s2_ovf <= 1'b0;
      end else if (w_s1_adv) begin
         r_s2_ovf <= w_ovf;
      end else begin
         r_s2_ovf <= r_s2_ovf;
      end
   end

   assign out_ovf = r_s2_ovf;
`else
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed vectors carry hand-computed results. Each accepted request pushes
// its expected result into a queue. A separate monitor pops the queue and
// compares whenever the DUT hands out a result. A behavioural yAlu closes
// the alu_* loop.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

   localparam int W  = 32;
   localparam int TW = 4;

   typedef struct packed {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [2:0]    op;
      logic [TW-1:0] tag;
      logic [W-1:0]  z;
      logic          zero;
      logic          err;
      logic          ovf;
   } vec_t;

   typedef struct packed {
      logic [W-1:0]  z;
      logic          zero;
      logic          err;
      logic [TW-1:0] tag;
      logic          ovf;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a, in_b;
   logic [2:0]    in_op;
   logic [TW-1:0] in_tag;
   logic [W-1:0]  alu_a, alu_b, alu_z;
   logic [2:0]    alu_op;
   logic          alu_ex;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_z;
   logic          out_zero, out_err, out_ovf;
   logic [TW-1:0] out_tag;

   vec_t vecs [16];
   exp_t cur_exp;
   exp_t sb [$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_z(alu_z), .alu_ex(alu_ex),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_zero(out_zero), .out_err(out_err),
      .out_tag(out_tag), .out_ovf(out_ovf)
   );

   // Behavioural yAlu
   always_comb begin
      alu_z = '0;
      case (alu_op)
         3'b000:  alu_z = alu_a & alu_b;
         3'b001:  alu_z = alu_a | alu_b;
         3'b010:  alu_z = alu_a + alu_b;
         3'b110:  alu_z = alu_a - alu_b;
         default: alu_z = '0;
      endcase
      alu_ex = (alu_z == '0);
   end

   function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic [TW-1:0] tag,
                               input logic [W-1:0] z, input logic zero,
                               input logic err, input logic ovf);
      vec_t v;
      v.a = a; v.b = b; v.op = op; v.tag = tag;
      v.z = z; v.zero = zero; v.err = err; v.ovf = ovf;
      return v;
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   // Scoreboard monitor: pop/compare on output handshake, push on input handshake
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output: got z=%h tag=%h, required no output", out_z, out_tag);
            end else begin
               e = sb.pop_front();
               if (out_z !== e.z || out_zero !== e.zero || out_err !== e.err ||
                   out_tag !== e.tag || out_ovf !== e.ovf) begin
                  fails++;
                  $display("FAIL result_tag%0h: got z=%h zero=%b err=%b tag=%h ovf=%b, required z=%h zero=%b err=%b tag=%h ovf=%b",
                           e.tag, out_z, out_zero, out_err, out_tag, out_ovf,
                           e.z, e.zero, e.err, e.tag, e.ovf);
               end
            end
         end
         if (in_valid && in_ready) sb.push_back(cur_exp);
      end
   end

   task automatic drive(input int idx);
      in_a   = vecs[idx].a;
      in_b   = vecs[idx].b;
      in_op  = vecs[idx].op;
      in_tag = vecs[idx].tag;
      cur_exp.z    = vecs[idx].z;
      cur_exp.zero = vecs[idx].zero;
      cur_exp.err  = vecs[idx].err;
      cur_exp.tag  = vecs[idx].tag;
`ifdef ALU_ISSUE_OVF_EN
      cur_exp.ovf  = vecs[idx].ovf;
`else
      cur_exp.ovf  = 1'b0;
`endif
      in_valid = 1'b1;
   endtask

   // Drive one request and wait (bounded) for its handshake
   task automatic send(input int idx);
      int n;
      drive(idx);
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout: got in_ready=0, required 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int c = 0; c < 50 && sb.size() > 0; c++) begin
         @(posedge clk); #1;
      end
      check("drain", sb.size(), 0);
   endtask

   initial begin
      int acc;
      vecs[0]  = mk(32'd5, 32'd7, 3'b010, 4'h3, 32'd12, 1'b0, 1'b0, 1'b0);
      vecs[1]  = mk(32'h1234, 32'h1234, 3'b110, 4'h1, 32'd0, 1'b1, 1'b0, 1'b0);
      vecs[2]  = mk(32'hF0, 32'h0F, 3'b000, 4'h2, 32'h0, 1'b1, 1'b0, 1'b0);
      vecs[3]  = mk(32'hF0, 32'h0F, 3'b001, 4'h4, 32'hFF, 1'b0, 1'b0, 1'b0);
      vecs[4]  = mk(32'd9, 32'd9, 3'b011, 4'h5, 32'd0, 1'b1, 1'b1, 1'b0);
      vecs[5]  = mk(32'h100, 32'h23, 3'b010, 4'h6, 32'h123, 1'b0, 1'b0, 1'b0);
      vecs[6]  = mk(32'h7FFFFFFF, 32'd1, 3'b010, 4'h7, 32'h80000000, 1'b0, 1'b0, 1'b1);
      vecs[7]  = mk(32'h80000000, 32'd1, 3'b110, 4'h8, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
      vecs[8]  = mk(32'd1, 32'd1, 3'b010, 4'h9, 32'd2, 1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(32'h10, 32'h3, 3'b110, 4'hA, 32'hD, 1'b0, 1'b0, 1'b0);
      vecs[10] = mk(32'h5, 32'hA, 3'b001, 4'hB, 32'hF, 1'b0, 1'b0, 1'b0);
      vecs[11] = mk(32'hFF, 32'h3C, 3'b000, 4'hC, 32'h3C, 1'b0, 1'b0, 1'b0);
      vecs[12] = mk(32'd2, 32'd2, 3'b010, 4'hD, 32'd4, 1'b0, 1'b0, 1'b0);
      vecs[13] = mk(32'd3, 32'd3, 3'b010, 4'hE, 32'd6, 1'b0, 1'b0, 1'b0);
      vecs[14] = mk(32'd1, 32'd2, 3'b111, 4'hF, 32'd0, 1'b1, 1'b1, 1'b0);
      vecs[15] = mk(32'd3, 32'd5, 3'b110, 4'h0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_op = 3'b000; in_tag = '0; cur_exp = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_out_z", out_z, 0);
      reset = 1'b0;

      // Latency: alu_* after the handshake edge, out_valid one edge later
      send(0);
      check("lat_alu_a", alu_a, 5);
      check("lat_alu_op", alu_op, 3'b010);
      check("lat_out_valid_early", out_valid, 0);
      @(posedge clk); #1;
      check("lat_out_valid", out_valid, 1);
      check("lat_out_z", out_z, 12);

      // Back-to-back stream including an illegal op
      send(1); send(2); send(3); send(4);
      check("illegal_alu_op", alu_op, 3'b000);
      send(5); send(6); send(7);
      drain();

      // Backpressure: four offered, three accepted
      out_ready = 1'b0;
      acc = 0;
      for (int i = 8; i < 12; i++) begin
         drive(i);
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp_accepted", acc, 3);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_tag", out_tag, 4'h9);
      repeat (3) @(posedge clk);
      #1;
      check("bp_stable_valid", out_valid, 1);
      check("bp_stable_z", out_z, 2);
      out_ready = 1'b1;
      drain();

      // Reset with two operations in flight
      out_ready = 1'b0;
      send(12); send(13);
      reset = 1'b1;
      @(posedge clk); #1;
      check("flush_out_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);
      check("flush_alu_a", alu_a, 0);
      check("flush_alu_b", alu_b, 0);
      check("flush_alu_op", alu_op, 0);
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      send(14); send(15);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
